// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D cache memory arbiter.
// FSM state encodings and owner codes.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb_lat_cnt.sv
// Loadable down-counter timing the fixed memory latency.
// last is high while the count sits at one.
module arb_lat_cnt #(
  parameter int MEM_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LOAD_V = CW'(MEM_LAT);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_V;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign last = (cnt == ONE);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache and D-cache miss traffic onto one memory port.
// D has priority; a starvation counter forces I through.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_done,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall,
  output logic              busy,
  output logic              owner
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [SW-1:0] S_ONE = SW'(1);

  arbState_t state;
  arbState_t nextState;

  logic              ownerQ;
  logic              wrQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] icRdataQ;
  logic [DATA_W-1:0] dcRdataQ;
  logic [SW-1:0]     starveCnt;

  logic forceI;
  logic grantI;
  logic grantD;
  logic grantAny;
  logic latLoad;
  logic latDec;
  logic latLast;

  always_comb begin
    forceI   = ic_req && (starveCnt == STARVE_TOP);
    grantI   = ic_req && (forceI || !dc_req);
    grantD   = dc_req && !forceI;
    grantAny = grantI || grantD;
  end

  assign latLoad = (state == ISSUE) && !mem_stall;
  assign latDec  = (state == WAIT);

  arb_lat_cnt #(
    .MEM_LAT(MEM_LAT)
  ) uLat (
    .clk (clk),
    .rst (rst),
    .load(latLoad),
    .dec (latDec),
    .last(latLast)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (grantAny) nextState = ISSUE;
      ISSUE: if (!mem_stall) nextState = WAIT;
      WAIT:  if (latLast) nextState = RESP;
      RESP:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ownerQ   <= OWN_I;
      wrQ      <= 1'b0;
      addrQ    <= '0;
      wdataQ   <= '0;
      icRdataQ <= '0;
      dcRdataQ <= '0;
    end else begin
      if (state == IDLE && grantAny) begin
        ownerQ <= grantD ? OWN_D : OWN_I;
        wrQ    <= grantD && dc_wr;
        addrQ  <= grantD ? dc_addr : ic_addr;
        wdataQ <= grantD ? dc_wdata : '0;
      end
      // Writes return nothing, so neither rdata register moves.
      if (state == WAIT && latLast && !wrQ) begin
        if (ownerQ == OWN_D) begin
          dcRdataQ <= mem_rdata;
        end else begin
          icRdataQ <= mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (state == IDLE) begin
      if (grantI || !ic_req) begin
        starveCnt <= '0;
      end else if (grantD && starveCnt != STARVE_TOP) begin
        starveCnt <= starveCnt + S_ONE;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    ic_done   = 1'b0;
    dc_done   = 1'b0;
    busy      = (state != IDLE);
    owner     = ownerQ;
    mem_addr  = addrQ;
    mem_wdata = wdataQ;
    ic_rdata  = icRdataQ;
    dc_rdata  = dcRdataQ;
    unique case (state)
      ISSUE: begin
        mem_en = 1'b1;
        mem_wr = wrQ;
      end
      RESP: begin
        ic_done = (ownerQ == OWN_I);
        dc_done = (ownerQ == OWN_D);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single multi-cycle main memory between the instruction-cache miss path and the data-cache miss/writeback path in proc_hier.
- Accepts one request at a time from either cache and latches its address and data.
- Issues the request to memory, counts the fixed memory latency, and returns read data with a one-cycle done pulse.
- Data side has priority; a starvation counter guarantees instruction-side forward progress.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- MEM_LAT, 4, cycles from the memory issue cycle to valid mem_rdata (>=1).
- STARVE_MAX, 3, consecutive D grants with ic_req pending before I is forced.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ic_req  in  1  I-side read request, level, held until ic_done.
- ic_addr  in  ADDR_W  I-side address.
- ic_done  out  1  one-cycle pulse, I transaction complete.
- ic_rdata  out  DATA_W  I read data, valid when ic_done.
- dc_req  in  1  D-side request, level, held until dc_done.
- dc_wr  in  1  1 = write, 0 = read.
- dc_addr  in  ADDR_W  D-side address.
- dc_wdata  in  DATA_W  D write data.
- dc_done  out  1  one-cycle pulse, D transaction complete.
- dc_rdata  out  DATA_W  D read data, valid when dc_done on a read.
- mem_en  out  1  memory issue strobe.
- mem_wr  out  1  write qualifier for mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_stall  in  1  memory cannot accept an issue this cycle.
- busy  out  1  arbiter not in IDLE.
- owner  out  1  0 = I, 1 = D; valid while busy.

Behaviour:
- Reset (synchronous):
  - State IDLE; starve_cnt 0.
  - All outputs 0, including rdata registers.
- State IDLE:
  - Sample requests and select a winner.
  - If starve_cnt == STARVE_MAX and ic_req, grant I.
  - Otherwise grant D if dc_req, else I if ic_req.
  - On grant: latch owner, addr, wr (I is always read) and wdata; go to ISSUE.
- State ISSUE:
  - Drive mem_en = 1, mem_wr and mem_addr/mem_wdata from the latched values.
  - If mem_stall, stay in ISSUE with all outputs held.
  - Otherwise load lat_cnt = MEM_LAT and go to WAIT.
- State WAIT:
  - mem_en = 0; decrement lat_cnt each cycle.
  - When lat_cnt == 1: capture mem_rdata into the owner's rdata register (reads only) and go to RESP.
  - mem_stall is ignored in WAIT.
- State RESP:
  - Pulse the owner's done for exactly one cycle; go to IDLE.
  - Non-owner rdata is unchanged. Write transactions leave dc_rdata unchanged.
- Latency with no stall:
  - Request sampled in IDLE at cycle 0.
  - mem_en at cycle 1.
  - mem_rdata valid at cycle MEM_LAT+1.
  - done at cycle MEM_LAT+2.
  - Each stall cycle adds 1.
- Requester protocol:
  - Deassert req on the edge ending the done cycle.
  - IDLE follows RESP, so back-to-back grants never re-serve a finished request.
  - Inputs are ignored outside IDLE.
- Starvation counter:
  - Increments on each D grant made while ic_req is high, saturating at STARVE_MAX.
  - Clears on any I grant, or in any IDLE cycle with ic_req low.
- Simultaneous ic_req and dc_req: D wins unless starve_cnt == STARVE_MAX.
- Reset mid-operation (any state):
  - Abandon the transaction; no done pulse.
  - Return to IDLE next cycle with all outputs 0.
- The memory address never wraps or changes inside a transaction; it is taken from the latch.

Decomposition:
- Shared package cache_arb_pkg holds:
  - state encodings (IDLE, ISSUE, WAIT, RESP);
  - owner codes (OWN_I = 0, OWN_D = 1).
- One natural sub-module, arb_lat_cnt: loadable down-counter with a last-cycle flag, width clog2(MEM_LAT+1).

Test Plan:
- Single I read (MEM_LAT=4, no stall):
  - ic_req with ic_addr=0x0040; mem_rdata=0xBEEF at cycle 5.
  - Expect mem_en=1, mem_addr=0x0040 at cycle 1; ic_done=1, ic_rdata=0xBEEF at cycle 6; busy low at cycle 7.
- Simultaneous requests:
  - ic_req and dc_req (read 0x2000) at cycle 0.
  - Expect D granted first (dc_done cycle 6), then I granted in IDLE at cycle 7, mem_en cycle 8, ic_done cycle 13.
- Starvation (STARVE_MAX=3):
  - ic_req held; dc_req re-asserted immediately after each dc_done.
  - Expect exactly 3 D transactions, then an I grant, then starve_cnt=0 and D resumes.
- Stall:
  - mem_stall=1 for cycles 1–2 on a D read.
  - Expect mem_en held cycles 1–3 with a stable address, and dc_done at cycle 8.
- D write:
  - dc_wr=1, dc_addr=0x1000, dc_wdata=0x1234.
  - Expect mem_en=1, mem_wr=1, mem_wdata=0x1234 at cycle 1; dc_done at cycle 6; dc_rdata unchanged.
- Reset in WAIT:
  - rst=1 at cycle 3 of an I read.
  - Expect no ic_done, busy=0 and all outputs 0 at cycle 4; a fresh request afterwards completes with normal latency.
